// File: rtl/dst4_row_xform_pipe.sv
// dst4_row_xform_pipe: streaming 4-point HEVC DST (A4) row transform.
// One row per beat, forward (A4*x) or inverse (A4^T*x), with rounding shift
// and saturation. Two register stages (products, then rounded sums) sit
// behind a single global stall that is driven by the output handshake.
module dst4_row_xform_pipe #(
  parameter int IN_W    = 12,
  parameter int COEFF_W = 8,
  parameter int ACC_W   = IN_W + COEFF_W + 2,
  parameter int OUT_W   = IN_W + COEFF_W + 2,
  parameter int SHIFT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*IN_W-1:0]    in_row,
  input  logic                 mode,
  input  logic [SHIFT_W-1:0]   shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*OUT_W-1:0]   out_row,
  output logic                 out_last,
  output logic [1:0]           out_row_idx
);
  localparam int PROD_W = IN_W + COEFF_W;
  // Rounding works in a width wide enough that the largest rounding bias
  // (1 << (2^SHIFT_W - 2)) can never overflow the sum.
  localparam int RW = ACC_W + (1 << SHIFT_W) + 1;
  localparam logic signed [RW-1:0] SAT_HI = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SAT_LO = -SAT_HI - RW'(1);

  // A4 coefficient lookup, row-major.
  function automatic logic signed [COEFF_W-1:0] a4(input int r, input int c);
    int v;
    case (r * 4 + c)
      0:       v = 29;
      1:       v = 55;
      2:       v = 74;
      3:       v = 84;
      4:       v = 74;
      5:       v = 74;
      6:       v = 0;
      7:       v = -74;
      8:       v = 84;
      9:       v = -29;
      10:      v = -74;
      11:      v = 55;
      12:      v = 55;
      13:      v = -84;
      14:      v = 74;
      default: v = -29;
    endcase
    return COEFF_W'(v);
  endfunction

  // Round half up (then floor via arithmetic shift) and clamp to OUT_W.
  function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                 input logic [SHIFT_W-1:0]      sh);
    logic signed [RW-1:0] wide;
    logic signed [RW-1:0] r;
    wide = RW'(acc);
    if (sh != '0) wide = wide + (RW'(1) <<< (sh - 1'b1));
    r = wide >>> sh;
    if (r > SAT_HI) return SAT_HI[OUT_W-1:0];
    if (r < SAT_LO) return SAT_LO[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  logic                     adv;
  logic                     in_fire;
  logic                     eff_mode;
  logic [SHIFT_W-1:0]       eff_shift;
  logic [1:0]               row_cnt_q;
  logic                     mode_lat_q;
  logic [SHIFT_W-1:0]       shift_lat_q;
  logic                     s1_valid_q;
  logic [SHIFT_W-1:0]       s1_shift_q;
  logic [1:0]               s1_idx_q;
  logic signed [PROD_W-1:0] prod_d [16];
  logic signed [PROD_W-1:0] prod_q [16];
  logic [4*OUT_W-1:0]       out_row_d;
  logic [4*OUT_W-1:0]       out_row_q;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic [1:0]               out_idx_q;

  // Whole pipeline moves together; it only stops when a held output is refused.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign in_fire  = in_valid && adv;

  // Row 0 of a block takes mode/shift straight from the ports; later rows reuse the latch.
  assign eff_mode  = (row_cnt_q == 2'd0) ? mode  : mode_lat_q;
  assign eff_shift = (row_cnt_q == 2'd0) ? shift : shift_lat_q;

  // Product prod[j*4+k] = x[k] * A4[j][k] (forward) or x[k] * A4[k][j] (inverse).
  for (genvar gi = 0; gi < 4; gi++) begin : g_prod_row
    for (genvar gk = 0; gk < 4; gk++) begin : g_prod_col
      logic signed [IN_W-1:0]    x_k;
      logic signed [COEFF_W-1:0] coef;
      assign x_k  = in_row[gk*IN_W +: IN_W];
      assign coef = eff_mode ? a4(gk, gi) : a4(gi, gk);
      assign prod_d[gi*4+gk] = PROD_W'(x_k) * PROD_W'(coef);
    end
  end

  // Stage-2 combinational sum of the four registered products per output.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sum
    logic signed [ACC_W-1:0] acc;
    assign acc = ACC_W'(prod_q[gi*4])   + ACC_W'(prod_q[gi*4+1]) +
                 ACC_W'(prod_q[gi*4+2]) + ACC_W'(prod_q[gi*4+3]);
    assign out_row_d[gi*OUT_W +: OUT_W] = round_sat(acc, s1_shift_q);
  end

  // Stage-1 control plus block framing (row counter and per-block mode/shift latch).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_shift_q  <= '0;
      s1_idx_q    <= 2'd0;
      row_cnt_q   <= 2'd0;
      mode_lat_q  <= 1'b0;
      shift_lat_q <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_shift_q <= eff_shift;
        s1_idx_q   <= row_cnt_q;
        row_cnt_q  <= row_cnt_q + 2'd1;
        if (row_cnt_q == 2'd0) begin
          mode_lat_q  <= mode;
          shift_lat_q <= shift;
        end
      end
    end
  end

  // Stage-1 product registers; pure datapath, qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int i = 0; i < 16; i++) prod_q[i] <= prod_d[i];
    end
  end

  // Stage-2 output registers; held unchanged while the output is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= 2'd0;
      out_row_q   <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_row_q  <= out_row_d;
        out_last_q <= (s1_idx_q == 2'd3);
        out_idx_q  <= s1_idx_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_row     = out_row_q;
  assign out_last    = out_last_q;
  assign out_row_idx = out_idx_q;

endmodule

// File: tb/tb_dst4_row_xform_pipe.sv
// tb_dst4_row_xform_pipe: vector table plus scoreboard for the DST4 row pipe.
module tb_dst4_row_xform_pipe;
  localparam int IN_W    = 12;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_row = '0;
  logic        mode = 1'b0;
  logic [4:0]  shift = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_row;
  logic        out_last;
  logic [1:0]  out_row_idx;

  always #5 clk = ~clk;

  dst4_row_xform_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .mode(mode), .shift(shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .out_row_idx(out_row_idx)
  );

  typedef struct {
    logic [63:0] y;
    bit          last;
    logic [1:0]  idx;
    bit          chk_lat;
    int          hs_cyc;
  } exp_t;

  typedef struct {
    logic [47:0] row;
    bit          m;
    logic [4:0]  sh;
    logic [63:0] y;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   tb_cnt = 0;
  bit   tb_mode = 1'b0;
  logic [4:0] tb_shift = '0;
  int   A [4][4] = '{'{29, 55, 74, 84}, '{74, 74, 0, -74},
                     '{84, -29, -74, 55}, '{55, -84, 74, -29}};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] px(input int a, input int b, input int c, input int d);
    return {12'(d), 12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic logic [63:0] py(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Reference transform: full-precision sum, round half up, floor, clamp to 16 bits.
  function automatic logic [63:0] model(input logic [47:0] row, input bit m, input logic [4:0] sh);
    logic [63:0] y;
    longint acc, r, x;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) begin
        x = longint'($signed(row[k*12 +: 12]));
        acc += x * (m ? A[k][j] : A[j][k]);
      end
      if (sh == 0) r = acc;
      else r = (acc + (longint'(1) << (sh - 1))) >>> sh;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      y[j*16 +: 16] = r[15:0];
    end
    return y;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard pop on every accepted output row.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_row: got %h, required no row", out_row);
      end else begin
        e = sb.pop_front();
        $display("row out: y=%h idx=%0d last=%0d (expect y=%h idx=%0d last=%0d)",
                 out_row, out_row_idx, out_last, e.y, e.idx, e.last);
        check("row_data", out_row, e.y);
        check("row_last", 64'(out_last), 64'(e.last));
        check("row_idx", 64'(out_row_idx), 64'(e.idx));
        if (e.chk_lat) check("latency", 64'(cyc - e.hs_cyc), 64'd2);
      end
    end
  end

  // Drive one row; called and returns at posedge+1.
  task automatic send(input logic [47:0] row, input bit m, input logic [4:0] sh,
                      input bit use_tab, input logic [63:0] tab_y);
    exp_t e;
    int   guard;
    in_valid = 1'b1;
    in_row   = row;
    mode     = m;
    shift    = sh;
    guard    = 0;
    @(negedge clk);
    while (!in_ready) begin
      guard++;
      if (guard > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: got 0, required 1");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (tb_cnt == 0) begin
      tb_mode  = m;
      tb_shift = sh;
    end
    e.y       = use_tab ? tab_y : model(row, tb_mode, tb_shift);
    e.last    = (tb_cnt == 3);
    e.idx     = 2'(tb_cnt);
    e.chk_lat = use_tab;
    e.hs_cyc  = cyc;
    sb.push_back(e);
    last_hs = cyc;
    tb_cnt  = (tb_cnt + 1) % 4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    sb.delete();
    tb_cnt = 0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    vec_t tab [8];
    int   first_hs;
    tab[0] = '{px(1, 0, 0, 0), 1'b0, 5'd0, py(29, 74, 84, 55)};
    tab[1] = '{px(1, 0, 0, 0), 1'b1, 5'd0, py(29, 55, 74, 84)};
    tab[2] = '{px(0, 0, 0, -1), 1'b1, 5'd0, py(-55, 84, -74, 29)};
    tab[3] = '{px(64, 0, 0, 0), 1'b0, 5'd7, py(15, 37, 42, 28)};
    tab[4] = '{px(2047, 2047, 2047, 2047), 1'b0, 5'd0, py(32767, 32767, 32767, 32752)};
    tab[5] = '{px(-2048, -2048, -2048, -2048), 1'b0, 5'd0, py(-32768, -32768, -32768, -32768)};
    tab[6] = '{px(1, 1, 1, 1), 1'b0, 5'd1, py(121, 37, 18, 8)};
    tab[7] = '{px(-3, 0, 0, 0), 1'b1, 5'd2, py(-22, -41, -55, -63)};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_row", out_row, 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_idx", 64'(out_row_idx), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Table vectors, each as row 0 of a fresh block.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      $display("vector %0d: x=%h mode=%0d shift=%0d", i, tab[i].row, tab[i].m, tab[i].sh);
      send(tab[i].row, tab[i].m, tab[i].sh, 1'b1, tab[i].y);
      wait_drain();
    end

    // Eight back-to-back rows; mode changes on row 2 must not affect block 0.
    do_reset();
    first_hs = 0;
    for (int i = 0; i < 8; i++) begin
      send(px($urandom_range(0, 4095), $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095)),
           (i >= 2), (i == 4) ? 5'd1 : ((i == 0) ? 5'd2 : 5'(i + 3)), 1'b0, 64'd0);
      if (i == 0) first_hs = last_hs;
    end
    check("throughput", 64'(last_hs - first_hs), 64'd7);
    wait_drain();

    // Output stalled for three cycles mid-stream.
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(px($urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095)),
               1'b0, 5'd4, 1'b0, 64'd0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset after row 1 of a block; the next row starts a new block.
    do_reset();
    send(px(5, 6, 7, 8), 1'b0, 5'd0, 1'b0, 64'd0);
    send(px(9, 10, 11, 12), 1'b0, 5'd0, 1'b0, 64'd0);
    do_reset();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(px(1, 0, 0, 0), 1'b1, 5'd0, 1'b1, py(29, 55, 74, 84));
    send(px(0, 100, -100, 3), 1'b0, 5'd3, 1'b0, 64'd0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
